mygo_chan_select: RTL and testbench

- Downstream consumer of N mygo_fifo instances; implements a Go `select` over N receive channels.
- Round-robin arbitrates among FIFO outputs with valid data and forwards one word per cycle through a registered output stage.
- Tags each word with the index of the channel it came from.
- Sits between the channel FIFOs and the generated process logic that executes the chosen select case.

---
 rtl/mygo_chan_pkg.sv | 12 +
 rtl/mygo_rr_pick.sv | 46 ++++
 rtl/mygo_chan_select.sv | 102 ++++++++++
 tb/tb_mygo_chan_select.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mygo_chan_pkg.sv
// rtl/mygo_chan_pkg.sv - shared sizing helpers for the channel select block
package mygo_chan_pkg;

    // Width of the transfer counter; wraps modulo 2^CNT_W.
    localparam int CNT_W = 32;

    // Channel index width; a single channel still needs one bit so ports stay legal.
    function automatic int sel_bits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mygo_rr_pick.sv
// rtl/mygo_rr_pick.sv - combinational round-robin picker starting at ptr
module mygo_rr_pick
    import mygo_chan_pkg::*;
#(
    parameter int N        = 4,
    parameter int SEL_BITS = sel_bits(N)
) (
    input  logic [N-1:0]        req,
    input  logic [SEL_BITS-1:0] ptr,
    output logic [N-1:0]        gnt_onehot,
    output logic [SEL_BITS-1:0] gnt_idx,
    output logic                any
);

    logic [N-1:0] upper;

    // Requests at or above the pointer take priority; otherwise wrap to the lowest request.
    always_comb begin
        upper      = '0;
        gnt_onehot = '0;
        gnt_idx    = '0;
        for (int j = 0; j < N; j++) begin
            upper[j] = req[j] && (j >= int'(ptr));
        end
        if (|upper) begin
            for (int j = N - 1; j >= 0; j--) begin
                if (upper[j]) begin
                    gnt_onehot = '0;
                    gnt_onehot[j] = 1'b1;
                    gnt_idx = SEL_BITS'(j);
                end
            end
        end else begin
            for (int j = N - 1; j >= 0; j--) begin
                if (req[j]) begin
                    gnt_onehot = '0;
                    gnt_onehot[j] = 1'b1;
                    gnt_idx = SEL_BITS'(j);
                end
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/mygo_chan_select.sv
// rtl/mygo_chan_select.sv - round-robin select over N receive channels with registered output
module mygo_chan_select
    import mygo_chan_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int N        = 4,
    parameter int SEL_BITS = sel_bits(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_BITS-1:0]  out_sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CNT_W-1:0]     xfer_count
);

    logic [WIDTH-1:0]    out_data_q,  out_data_d;
    logic [SEL_BITS-1:0] out_sel_q,   out_sel_d;
    logic                out_valid_q, out_valid_d;
    logic [SEL_BITS-1:0] rr_ptr_q,    rr_ptr_d;
    logic [CNT_W-1:0]    xfer_q,      xfer_d;

    logic [N-1:0]        gnt_onehot;
    logic [SEL_BITS-1:0] gnt_idx;
    logic                any;
    logic                load;
    logic                take;
    logic [WIDTH-1:0]    gnt_data;

    mygo_rr_pick #(
        .N        (N),
        .SEL_BITS (SEL_BITS)
    ) u_pick (
        .req        (in_valid),
        .ptr        (rr_ptr_q),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (any)
    );

    // The output slot is free when empty or being drained this cycle.
    assign load = !out_valid_q || out_ready;
    assign take = load && any;

    // Pop strobe goes only to the granted FIFO, and never while reset is held.
    assign in_ready = (take && rst) ? gnt_onehot : '0;

    // One-hot AND-OR mux so data on non-valid channels cannot leak through.
    always_comb begin
        gnt_data = '0;
        for (int j = 0; j < N; j++) begin
            if (gnt_onehot[j]) begin
                gnt_data = gnt_data | in_data[j*WIDTH +: WIDTH];
            end
        end
    end

    // Next state: capture on a grant, empty on an idle load, hold under backpressure.
    always_comb begin
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        xfer_d      = xfer_q;
        if (take) begin
            out_data_d  = gnt_data;
            out_sel_d   = gnt_idx;
            out_valid_d = 1'b1;
            rr_ptr_d    = (gnt_idx == SEL_BITS'(N - 1)) ? '0 : gnt_idx + SEL_BITS'(1);
            xfer_d      = xfer_q + CNT_W'(1);
        end else if (load) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset drops any word in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
            xfer_q      <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
            xfer_q      <= xfer_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_sel    = out_sel_q;
    assign out_valid  = out_valid_q;
    assign xfer_count = xfer_q;

endmodule

// File: tb/tb_mygo_chan_select.sv
// tb/tb_mygo_chan_select.sv - directed self-checking bench for mygo_chan_select
module tb_mygo_chan_select;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] xfer_count;

    logic [7:0]  in1_data;
    logic        in1_valid;
    logic        in1_ready;
    logic [7:0]  out1_data;
    logic        out1_sel;
    logic        out1_valid;
    logic        out1_ready;
    logic [31:0] xfer1_count;

    int n_checks;
    int n_fail;

    mygo_chan_select #(.WIDTH(8), .N(4)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_sel    (out_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .xfer_count (xfer_count)
    );

    mygo_chan_select #(.WIDTH(8), .N(1)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in1_data),
        .in_valid   (in1_valid),
        .in_ready   (in1_ready),
        .out_data   (out1_data),
        .out_sel    (out1_sel),
        .out_valid  (out1_valid),
        .out_ready  (out1_ready),
        .xfer_count (xfer1_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] d, input logic [1:0] s, input logic [31:0] cnt);
        check_eq({tag, ".valid"}, 32'(out_valid), 32'd1);
        check_eq({tag, ".data"},  32'(out_data),  32'(d));
        check_eq({tag, ".sel"},   32'(out_sel),   32'(s));
        check_eq({tag, ".count"}, xfer_count,     cnt);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b0;
        in_valid   = 4'b1111;
        in_data    = 32'h13121110;
        out_ready  = 1'b1;
        in1_valid  = 1'b0;
        in1_data   = 8'h00;
        out1_ready = 1'b1;

        // Reset state before any clock edge.
        #2;
        check_eq("rst.in_ready",  32'(in_ready),  32'h0);
        check_eq("rst.out_valid", 32'(out_valid), 32'h0);
        check_eq("rst.out_data",  32'(out_data),  32'h0);
        check_eq("rst.count",     xfer_count,     32'h0);

        tick();
        rst      = 1'b1;
        in_valid = 4'b0000;

        // Single source on channel 2.
        in_valid = 4'b0100;
        in_data  = 32'h00A50000;
        #1;
        check_eq("single.in_ready", 32'(in_ready), 32'b0100);
        tick();
        expect_out("single", 8'hA5, 2'd2, 32'd1);

        // Fresh pointer for the fairness sweep.
        rst = 1'b0;
        #1;
        rst = 1'b1;
        in_valid = 4'b1111;
        in_data  = 32'h13121110;
        for (int k = 0; k < 5; k++) begin
            tick();
            expect_out($sformatf("fair%0d", k), 8'(8'h10 + k % 4), 2'(k % 4), 32'(k + 1));
        end

        // Load sel 1, then stall three cycles.
        tick();
        expect_out("bp.load", 8'h11, 2'd1, 32'd6);
        out_ready = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("bp%0d.in_ready", k), 32'(in_ready), 32'h0);
            tick();
            expect_out($sformatf("bp%0d", k), 8'h11, 2'd1, 32'd6);
        end
        out_ready = 1'b1;
        #1;
        check_eq("bp.release.in_ready", 32'(in_ready), 32'b0100);
        tick();
        expect_out("bp.next", 8'h12, 2'd2, 32'd7);

        // Pointer at 3, only channels 0 and 1 requesting.
        in_valid = 4'b0011;
        #1;
        check_eq("wrap.in_ready", 32'(in_ready), 32'b0001);
        tick();
        expect_out("wrap0", 8'h10, 2'd0, 32'd8);
        tick();
        expect_out("wrap1", 8'h11, 2'd1, 32'd9);

        // Nothing requesting: output empties, data and sel hold.
        in_valid = 4'b0000;
        tick();
        check_eq("idle.valid", 32'(out_valid), 32'd0);
        check_eq("idle.data",  32'(out_data),  32'h11);
        check_eq("idle.sel",   32'(out_sel),   32'd1);
        check_eq("idle.count", xfer_count,     32'd9);

        // Reset mid-stream clears immediately.
        in_valid = 4'b1111;
        tick();
        expect_out("mid.pre", 8'h12, 2'd2, 32'd10);
        #2;
        rst = 1'b0;
        #1;
        check_eq("mid.valid",    32'(out_valid), 32'd0);
        check_eq("mid.data",     32'(out_data),  32'h0);
        check_eq("mid.sel",      32'(out_sel),   32'd0);
        check_eq("mid.count",    xfer_count,     32'd0);
        check_eq("mid.in_ready", 32'(in_ready),  32'h0);
        rst = 1'b1;
        tick();
        expect_out("mid.post", 8'h10, 2'd0, 32'd1);

        // Single-channel instance as a register slice.
        in_valid  = 4'b0000;
        in1_valid = 1'b1;
        in1_data  = 8'h3C;
        out1_ready = 1'b1;
        #1;
        check_eq("n1.in_ready0", 32'(in1_ready), 32'd1);
        tick();
        check_eq("n1.valid0", 32'(out1_valid), 32'd1);
        check_eq("n1.data0",  32'(out1_data),  32'h3C);
        check_eq("n1.sel0",   32'(out1_sel),   32'd0);
        check_eq("n1.count0", xfer1_count,     32'd1);
        out1_ready = 1'b0;
        in1_data   = 8'h3D;
        #1;
        check_eq("n1.in_ready1", 32'(in1_ready), 32'd0);
        tick();
        check_eq("n1.data1",  32'(out1_data), 32'h3C);
        check_eq("n1.count1", xfer1_count,    32'd1);
        out1_ready = 1'b1;
        #1;
        check_eq("n1.in_ready2", 32'(in1_ready), 32'd1);
        tick();
        check_eq("n1.data2",  32'(out1_data), 32'h3D);
        check_eq("n1.count2", xfer1_count,    32'd2);
        in1_valid = 1'b0;
        tick();
        check_eq("n1.valid3", 32'(out1_valid), 32'd0);
        check_eq("n1.count3", xfer1_count,     32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
